// File: rtl/turn_dec_pkg.sv
// Shared types for the turn-signal decoder: FSM states, dir encodings and lamp pattern classes.
// Hazard states are compiled in only when TURN_DEC_HAZARD_EN is defined.
package turn_dec_pkg;

  typedef enum logic [3:0] {
    IDLE,
    L1S,
    L2S,
    L3S,
    R1S,
    R2S,
    R3S,
`ifdef TURN_DEC_HAZARD_EN
    H1S,
    H2S,
    H3S,
`endif
    ERR
  } state_e;

  typedef enum logic [2:0] {
    OFF,
    S1,
    S2,
    S3,
    BAD
  } pat_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_HAZ   = 2'b11;

  function automatic logic [1:0] dir_of(input state_e s);
    case (s)
      L1S, L2S, L3S: dir_of = DIR_LEFT;
      R1S, R2S, R3S: dir_of = DIR_RIGHT;
`ifdef TURN_DEC_HAZARD_EN
      H1S, H2S, H3S: dir_of = DIR_HAZ;
`endif
      default:       dir_of = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/turn_signal_decoder_classify.sv
// Combinational classifier mapping one side's {x1,x2,x3} lamp bits to a pattern class.
module lamp_pattern_classify
  import turn_dec_pkg::*;
(
  input  logic [2:0] i_bits,
  output pat_e       o_pat
);

  always_comb begin
    o_pat = BAD;
    case (i_bits)
      3'b000:  o_pat = OFF;
      3'b100:  o_pat = S1;
      3'b110:  o_pat = S2;
      3'b111:  o_pat = S3;
      default: o_pat = BAD;
    endcase
  end

endmodule

// File: rtl/turn_signal_decoder.sv
// Monitor that tracks the lamp FSM sweep protocol and reports direction, sweep completion and errors.
// Define TURN_DEC_HAZARD_EN to accept hazard (both sides in lockstep) sweeps.
module turn_signal_decoder
  import turn_dec_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             L1,
  input  logic             L2,
  input  logic             L3,
  input  logic             R1,
  input  logic             R2,
  input  logic             R3,
  output logic [1:0]       dir,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] sweep_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  logic [1:0]       r_dir;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  state_e     w_next;
  logic       w_done_next;
  logic [2:0] w_side_bits [2];
  pat_e       w_pat [2];
  logic       w_l_off;
  logic       w_r_off;
  logic       w_both_off;

  assign w_side_bits[0] = {L1, L2, L3};
  assign w_side_bits[1] = {R1, R2, R3};

  // Index 0 is the left side, index 1 the right side.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
      lamp_pattern_classify u_classify (
        .i_bits (w_side_bits[gi]),
        .o_pat  (w_pat[gi])
      );
    end
  endgenerate

  assign w_l_off    = (w_pat[0] == OFF);
  assign w_r_off    = (w_pat[1] == OFF);
  assign w_both_off = w_l_off && w_r_off;

  always_comb begin
    w_next      = r_state;
    w_done_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_both_off)                      w_next = IDLE;
        else if (w_pat[0] == S1 && w_r_off)  w_next = L1S;
        else if (w_pat[1] == S1 && w_l_off)  w_next = R1S;
`ifdef TURN_DEC_HAZARD_EN
        else if (w_pat[0] == S1 && w_pat[1] == S1) w_next = H1S;
`endif
        else                                 w_next = ERR;
      end
      L1S: begin
        if (w_both_off)                      w_next = IDLE;
        else if (w_pat[0] == S2 && w_r_off)  w_next = L2S;
        else                                 w_next = ERR;
      end
      L2S: begin
        if (w_both_off)                      w_next = IDLE;
        else if (w_pat[0] == S3 && w_r_off)  w_next = L3S;
        else                                 w_next = ERR;
      end
      R1S: begin
        if (w_both_off)                      w_next = IDLE;
        else if (w_pat[1] == S2 && w_l_off)  w_next = R2S;
        else                                 w_next = ERR;
      end
      R2S: begin
        if (w_both_off)                      w_next = IDLE;
        else if (w_pat[1] == S3 && w_l_off)  w_next = R3S;
        else                                 w_next = ERR;
      end
`ifdef TURN_DEC_HAZARD_EN
      H1S: begin
        if (w_both_off)                              w_next = IDLE;
        else if (w_pat[0] == S2 && w_pat[1] == S2)   w_next = H2S;
        else                                         w_next = ERR;
      end
      H2S: begin
        if (w_both_off)                              w_next = IDLE;
        else if (w_pat[0] == S3 && w_pat[1] == S3)   w_next = H3S;
        else                                         w_next = ERR;
      end
      L3S, R3S, H3S: begin
`else
      L3S, R3S: begin
`endif
        // Only a dark frame after the third step completes a sweep.
        if (w_both_off) begin
          w_next      = IDLE;
          w_done_next = 1'b1;
        end else begin
          w_next = ERR;
        end
      end
      ERR: begin
        if (w_both_off) w_next = IDLE;
        else            w_next = ERR;
      end
      default: w_next = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dir   <= DIR_NONE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_dir   <= dir_of(w_next);
      r_done  <= w_done_next;
      r_err   <= r_err || (w_next == ERR);
      if (w_done_next && r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dir       = r_dir;
  assign done      = r_done;
  assign err       = r_err;
  assign sweep_cnt = r_cnt;

endmodule
